cpu_dmem_slave: RTL and testbench
=================================

// Module: cpu_dmem_slave
// PURPOSE
//  Wishbone-classic slave data memory. Answers the 16-bit data-memory master port of the
//  mox125 execute stage (dmem_*). Holds 2^(ADDR_WIDTH-1) halfwords of on-chip RAM inside
//  one aligned address window. Supports programmable wait states, per-lane byte writes,
//  and an error response for addresses outside the window.
// PARAMETERS
//  ADDR_WIDTH   12      byte-address bits decoded inside the window; RAM = 2^(ADDR_WIDTH-1) x 16
//  BASE_ADDR    32'h0   window base; bits [ADDR_WIDTH-1:0] must be zero
//  WAIT_STATES  1       extra cycles between accept and ack; legal range 0..15
// PORTS
//  clk_i      in   1   clock; all logic on posedge
//  rst_i      in   1   synchronous reset, active-high
//  wb_adr_i   in   32  byte address; bit 0 ignored (halfword-indexed by [ADDR_WIDTH-1:1])
//  wb_dat_i   in   16  write data
//  wb_dat_o   out  16  read data, valid while wb_ack_o=1 on a read
//  wb_sel_i   in   2   lane enables: [1] -> dat[15:8], [0] -> dat[7:0]
//  wb_we_i    in   1   1=write, 0=read
//  wb_stb_i   in   1   strobe
//  wb_cyc_i   in   1   bus cycle valid
//  wb_ack_o   out  1   normal termination, one-cycle pulse
//  wb_err_o   out  1   error termination (out of window), one-cycle pulse
// BEHAVIOUR
//  Reset (rst_i=1 at posedge): state=IDLE, wait counter=0, wb_ack_o=0, wb_err_o=0,
//   wb_dat_o=16'h0. RAM contents are not cleared. Reset mid-transaction: the transaction is
//   dropped with no ack, no err and no RAM write.
//  FSM states: IDLE, WAIT, ACK, ERR.
//  IDLE: when cyc&stb=1, latch adr/dat/sel/we (the "accept" cycle N).
//   Out of window (adr[31:ADDR_WIDTH] != BASE_ADDR[31:ADDR_WIDTH]) -> ERR.
//   In window with WAIT_STATES=0 -> ACK.
//   Otherwise load counter with WAIT_STATES-1 -> WAIT.
//  WAIT: if cyc=0 or stb=0 -> IDLE (abort: no write, no ack). Else if counter=0 -> ACK,
//   else decrement the counter.
//  Entry to ACK (registered): on a write, RAM lanes selected by the latched sel are written
//   at that edge; sel=2'b00 writes nothing but is still acked. On a read, wb_dat_o loads the
//   RAM word at that edge. wb_ack_o=1 for exactly one cycle.
//  ACK -> IDLE unconditionally. ERR: wb_err_o=1 for one cycle, no RAM access, wb_dat_o
//   unchanged, then -> IDLE.
//  Latency: ack/err goes high in cycle N+1+WAIT_STATES (ERR is always N+1).
//  Back-to-back: IDLE does not accept in the cycle ack/err is high, so there is a minimum
//   of one idle cycle between terminations. A master that holds stb after ack is accepted
//   again on the following cycle.
//  wb_dat_o holds its last read value through writes, errors and idle cycles.
//  wb_ack_o and wb_err_o are never high together. Neither is asserted while cyc=0, except
//   the single registered pulse that follows an abort in the same cycle as entry to ACK.
//  Read-after-write to the same address returns the new data (the write commits before any
//   later read samples the RAM).
//  The top window address wraps nothing: an address at BASE+2^ADDR_WIDTH is out of window
//   and gets ERR.
// TESTING
//  1 WAIT_STATES=1: write adr=0x10, dat=0xBEEF, sel=11 at cycle N -> ack at N+2; then read
//    adr=0x10 -> ack at N+2 of the read, dat_o=0xBEEF.
//  2 Byte lanes: after writing 0xBEEF, write sel=01 dat=0x0012 -> read gives 0xBE12; write
//    sel=10 dat=0x3400 -> read gives 0x3412; sel=00 write is acked, data unchanged.
//  3 Out of window: BASE=0, ADDR_WIDTH=12, read adr=0x1000 -> err at N+1, ack stays 0,
//    dat_o unchanged, RAM unchanged.
//  4 Abort: WAIT_STATES=3, write accepted, stb dropped after 1 cycle -> no ack, and a
//    follow-up read of that address returns the old value.
//  5 Reset mid-op: rst_i=1 during WAIT -> next cycle ack=0, err=0, dat_o=0; a new
//    transaction after reset completes with the normal latency.
//  6 WAIT_STATES=0 back-to-back: stb held high for 3 reads -> acks at N+1, N+3, N+5.

Source files
------------

// File: rtl/cpu_dmem_slave.sv
// Wishbone-classic 16-bit data-memory slave for the mox125 execute stage.
// One aligned address window of on-chip RAM, programmable wait states, byte lanes, error outside.
module cpu_dmem_slave #(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] wb_adr_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  input  logic [1:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  output logic        wb_err_o
);

  localparam int unsigned IdxW     = ADDR_WIDTH - 1;
  localparam int unsigned Words    = 2 ** IdxW;
  localparam logic [3:0]  WaitLoad = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {StIdle, StWait, StAck, StErr} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [IdxW-1:0] idx_q;
  logic [15:0]     wdat_q;
  logic [1:0]      sel_q;
  logic            we_q;
  logic [15:0]     rdat_q;
  logic [15:0]     mem [Words];

  logic            req, in_win, accept, enter_ack;
  logic [IdxW-1:0] eff_idx;
  logic [15:0]     eff_dat;
  logic [1:0]      eff_sel;
  logic            eff_we;
  logic            unused_adr0;

  assign unused_adr0 = wb_adr_i[0];
  assign req         = wb_cyc_i & wb_stb_i;
  assign in_win      = (wb_adr_i >> ADDR_WIDTH) == (BASE_ADDR >> ADDR_WIDTH);
  assign accept      = (state_q == StIdle) && req;
  assign enter_ack   = (state_d == StAck) && !rst_i;

  // With zero wait states the RAM is accessed on the accept edge, before the latch is loaded.
  always_comb begin
    if (state_q == StIdle) begin
      eff_idx = wb_adr_i[ADDR_WIDTH-1:1];
      eff_dat = wb_dat_i;
      eff_sel = wb_sel_i;
      eff_we  = wb_we_i;
    end else begin
      eff_idx = idx_q;
      eff_dat = wdat_q;
      eff_sel = sel_q;
      eff_we  = we_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (!in_win) begin
            state_d = StErr;
          end else if (WAIT_STATES == 0) begin
            state_d = StAck;
          end else begin
            state_d = StWait;
            cnt_d   = WaitLoad;
          end
        end
      end
      StWait: begin
        if (!req) begin
          state_d = StIdle;
        end else if (cnt_q == 4'd0) begin
          state_d = StAck;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StAck, StErr: state_d = StIdle;
      default:      state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      rdat_q  <= 16'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (enter_ack && !eff_we) begin
        rdat_q <= mem[eff_idx];
      end
    end
  end

  // Request latch and RAM carry no reset; RAM contents survive reset.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      idx_q  <= wb_adr_i[ADDR_WIDTH-1:1];
      wdat_q <= wb_dat_i;
      sel_q  <= wb_sel_i;
      we_q   <= wb_we_i;
    end
    if (enter_ack && eff_we) begin
      if (eff_sel[0]) mem[eff_idx][7:0]  <= eff_dat[7:0];
      if (eff_sel[1]) mem[eff_idx][15:8] <= eff_dat[15:8];
    end
  end

  assign wb_ack_o = (state_q == StAck);
  assign wb_err_o = (state_q == StErr);
  assign wb_dat_o = rdat_q;

endmodule

// File: tb/tb_cpu_dmem_slave.sv
// Directed bench for cpu_dmem_slave: three instances with 1, 3 and 0 wait states.
module tb_cpu_dmem_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] adr = '0;
  logic [15:0] dat = '0;
  logic [1:0]  sel = '0;
  logic        we  = 1'b0;
  logic        cyc = 1'b0;
  logic [2:0]  stb = '0;
  logic [2:0]  ack, err;
  logic [15:0] dout [3];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cpu_dmem_slave #(.WAIT_STATES(1)) u_ws1 (
    .clk_i(clk), .rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat), .wb_dat_o(dout[0]),
    .wb_sel_i(sel), .wb_we_i(we), .wb_stb_i(stb[0]), .wb_cyc_i(cyc),
    .wb_ack_o(ack[0]), .wb_err_o(err[0])
  );

  cpu_dmem_slave #(.WAIT_STATES(3)) u_ws3 (
    .clk_i(clk), .rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat), .wb_dat_o(dout[1]),
    .wb_sel_i(sel), .wb_we_i(we), .wb_stb_i(stb[1]), .wb_cyc_i(cyc),
    .wb_ack_o(ack[1]), .wb_err_o(err[1])
  );

  cpu_dmem_slave #(.WAIT_STATES(0)) u_ws0 (
    .clk_i(clk), .rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat), .wb_dat_o(dout[2]),
    .wb_sel_i(sel), .wb_we_i(we), .wb_stb_i(stb[2]), .wb_cyc_i(cyc),
    .wb_ack_o(ack[2]), .wb_err_o(err[2])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs one transaction on instance k; lat counts cycles from accept to termination.
  task automatic xfer(input int k, input logic w, input logic [31:0] a, input logic [15:0] d,
                      input logic [1:0] s, output int lat, output logic got_err);
    adr = a; dat = d; sel = s; we = w; cyc = 1'b1; stb[k] = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!ack[k] && !err[k] && lat < 20);
    got_err = err[k];
    check("ack_err_exclusive", 32'(ack[k] & err[k]), 32'd0);
    cyc = 1'b0; stb[k] = 1'b0; we = 1'b0;
    tick();
  endtask

  int         lat;
  logic       e;
  logic       seen;
  logic [5:0] pat;

  initial begin
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("reset_ack", 32'(ack[0]), 32'd0);
    check("reset_err", 32'(err[0]), 32'd0);
    check("reset_dat", 32'(dout[0]), 32'h0);

    // Full write then read, one wait state
    xfer(0, 1'b1, 32'h10, 16'hBEEF, 2'b11, lat, e);
    check("wr_latency", lat, 2);
    check("wr_err", 32'(e), 32'd0);
    xfer(0, 1'b0, 32'h10, 16'h0, 2'b11, lat, e);
    check("rd_latency", lat, 2);
    check("rd_data", 32'(dout[0]), 32'hBEEF);

    // Byte lanes
    xfer(0, 1'b1, 32'h10, 16'h0012, 2'b01, lat, e);
    xfer(0, 1'b0, 32'h10, 16'h0, 2'b11, lat, e);
    check("lane0_data", 32'(dout[0]), 32'hBE12);
    xfer(0, 1'b1, 32'h10, 16'h3400, 2'b10, lat, e);
    xfer(0, 1'b0, 32'h10, 16'h0, 2'b11, lat, e);
    check("lane1_data", 32'(dout[0]), 32'h3412);
    xfer(0, 1'b1, 32'h11, 16'hFFFF, 2'b00, lat, e);
    check("sel00_latency", lat, 2);
    check("sel00_err", 32'(e), 32'd0);
    xfer(0, 1'b0, 32'h10, 16'h0, 2'b11, lat, e);
    check("sel00_data", 32'(dout[0]), 32'h3412);

    // Out of window, including the first address past the top
    xfer(0, 1'b0, 32'h1000, 16'h0, 2'b11, lat, e);
    check("oow_err", 32'(e), 32'd1);
    check("oow_latency", lat, 1);
    check("oow_dat_hold", 32'(dout[0]), 32'h3412);
    xfer(0, 1'b1, 32'h8000_0010, 16'h5A5A, 2'b11, lat, e);
    check("oow_hi_err", 32'(e), 32'd1);
    xfer(0, 1'b0, 32'h10, 16'h0, 2'b11, lat, e);
    check("oow_ram_kept", 32'(dout[0]), 32'h3412);
    xfer(0, 1'b0, 32'hFFE, 16'h0, 2'b11, lat, e);
    check("top_in_window", 32'(e), 32'd0);

    // Abort with three wait states
    xfer(1, 1'b1, 32'h20, 16'h1111, 2'b11, lat, e);
    check("ws3_wr_latency", lat, 4);
    adr = 32'h20; dat = 16'h2222; sel = 2'b11; we = 1'b1; cyc = 1'b1; stb[1] = 1'b1;
    tick();
    stb[1] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen = seen | ack[1] | err[1];
    end
    cyc = 1'b0; we = 1'b0;
    check("abort_no_ack", 32'(seen), 32'd0);
    xfer(1, 1'b0, 32'h20, 16'h0, 2'b11, lat, e);
    check("abort_rd_latency", lat, 4);
    check("abort_old_data", 32'(dout[1]), 32'h1111);

    // Reset in the middle of a wait
    xfer(0, 1'b1, 32'h30, 16'h7777, 2'b11, lat, e);
    adr = 32'h30; dat = 16'h5555; sel = 2'b11; we = 1'b1; cyc = 1'b1; stb[0] = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; cyc = 1'b0; stb[0] = 1'b0; we = 1'b0;
    check("rst_mid_ack", 32'(ack[0]), 32'd0);
    check("rst_mid_err", 32'(err[0]), 32'd0);
    check("rst_mid_dat", 32'(dout[0]), 32'h0);
    xfer(0, 1'b0, 32'h30, 16'h0, 2'b11, lat, e);
    check("post_rst_latency", lat, 2);
    check("post_rst_data", 32'(dout[0]), 32'h7777);

    // Zero wait states, strobe held across three reads
    xfer(2, 1'b1, 32'h40, 16'hA5A5, 2'b11, lat, e);
    check("ws0_wr_latency", lat, 1);
    adr = 32'h40; sel = 2'b11; we = 1'b0; cyc = 1'b1; stb[2] = 1'b1;
    pat = '0;
    for (int i = 0; i < 6; i++) begin
      tick();
      pat = {pat[4:0], ack[2]};
    end
    cyc = 1'b0; stb[2] = 1'b0;
    check("b2b_ack_pattern", 32'(pat), 32'b101010);
    check("b2b_data", 32'(dout[2]), 32'hA5A5);
    xfer(2, 1'b0, 32'h1000, 16'h0, 2'b11, lat, e);
    check("ws0_oow_latency", lat, 1);
    check("ws0_oow_err", 32'(e), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
